// File: rtl/elevator_cabin_ctrl.sv
// Cabin motion controller: steps the cabin one floor per travel interval toward the
// comparator's target, then holds the door open and pulses reqServed.
module elevator_cabin_ctrl #(
  parameter int unsigned TRAVEL_CYCLES = 50,
  parameter int unsigned DOOR_CYCLES   = 20,
  parameter logic [1:0]  HOME_FLOOR    = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reqValid,
  input  logic       down_upFlag,
  input  logic       stop_goFlag,
  output logic [1:0] actualFloor,
  output logic       motorUp,
  output logic       motorDown,
  output logic       doorOpen,
  output logic       reqServed,
  output logic       busy
);

  // state     | meaning
  // IDLE      | no motion, door closed; evaluates request each cycle
  // MOVE_UP   | motor up for TRAVEL_CYCLES, floor increments on exit
  // MOVE_DOWN | motor down for TRAVEL_CYCLES, floor decrements on exit
  // ARRIVE    | one settle cycle for the comparator, then re-evaluate
  // DOOR      | door open for DOOR_CYCLES, reqServed in the last cycle
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    ARRIVE    = 3'd3,
    DOOR      = 3'd4
  } state_t;

  localparam int unsigned MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    floor_q, floor_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      floor_q <= HOME_FLOOR;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    timer_d = timer_q;
    case (state_q)
      IDLE, ARRIVE: begin
        // Floor guards keep actualFloor from wrapping on bad direction flags.
        state_d = IDLE;
        timer_d = '0;
        if (reqValid) begin
          if (stop_goFlag) begin
            state_d = DOOR;
            timer_d = DOOR_LOAD;
          end else if (down_upFlag && (floor_q != 2'd3)) begin
            state_d = MOVE_UP;
            timer_d = TRAVEL_LOAD;
          end else if (!down_upFlag && (floor_q != 2'd0)) begin
            state_d = MOVE_DOWN;
            timer_d = TRAVEL_LOAD;
          end
        end
      end
      MOVE_UP: begin
        if (timer_q == '0) begin
          state_d = ARRIVE;
          floor_d = floor_q + 2'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      MOVE_DOWN: begin
        if (timer_q == '0) begin
          state_d = ARRIVE;
          floor_d = floor_q - 2'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DOOR: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign actualFloor = floor_q;
  assign motorUp     = (state_q == MOVE_UP);
  assign motorDown   = (state_q == MOVE_DOWN);
  assign doorOpen    = (state_q == DOOR);
  assign reqServed   = (state_q == DOOR) && (timer_q == '0);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_cabin_ctrl.sv
// Directed bench for elevator_cabin_ctrl: per-cycle expected outputs are queued
// with each stimulus step and popped/compared one cycle at a time.
module tb_elevator_cabin_ctrl;

  localparam int unsigned TRAVEL = 4;
  localparam int unsigned DOORC  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reqValid;
  logic       down_upFlag;
  logic       stop_goFlag;
  logic [1:0] actualFloor;
  logic       motorUp, motorDown, doorOpen, reqServed, busy;

  logic [1:0] target;
  logic       ovr, ovr_dir, ovr_stop;

  int errors = 0;
  int checks = 0;
  int idx    = 0;
  string test_name = "init";

  // {floor[1:0], up, down, door, served, busy}
  logic [5:0] exp_q[$];

  elevator_cabin_ctrl #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DOORC),
    .HOME_FLOOR(2'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reqValid(reqValid),
    .down_upFlag(down_upFlag),
    .stop_goFlag(stop_goFlag),
    .actualFloor(actualFloor),
    .motorUp(motorUp),
    .motorDown(motorDown),
    .doorOpen(doorOpen),
    .reqServed(reqServed),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Floor comparator model, with an override for forcing illegal flag combinations.
  always_comb begin
    if (ovr) begin
      down_upFlag = ovr_dir;
      stop_goFlag = ovr_stop;
    end else begin
      down_upFlag = (target >= actualFloor);
      stop_goFlag = (target == actualFloor);
    end
  end

  task automatic push(input logic [1:0] fl, input logic up, input logic dn,
                      input logic door, input logic srv, input logic bsy);
    exp_q.push_back({fl, up, dn, door, srv, bsy});
  endtask

  task automatic e_idle(input int n, input logic [1:0] fl);
    for (int i = 0; i < n; i++) push(fl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic e_up(input int n, input logic [1:0] fl);
    for (int i = 0; i < n; i++) push(fl, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic e_dn(input int n, input logic [1:0] fl);
    for (int i = 0; i < n; i++) push(fl, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic e_arr(input logic [1:0] fl);
    push(fl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic e_door(input logic [1:0] fl);
    for (int i = 0; i < int'(DOORC) - 1; i++) push(fl, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(fl, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic cmp_one();
    logic [5:0] obs, exp;
    obs = {actualFloor, motorUp, motorDown, doorOpen, reqServed, busy};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s[%0d] scoreboard empty observed=%b", test_name, idx, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s[%0d] observed=%b expected=%b (floor,up,dn,door,srv,busy)",
               test_name, idx, obs, exp);
      end
    end
    idx++;
  endtask

  task automatic chk(input int n);
    for (int i = 0; i < n; i++) begin
      cmp_one();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input string name);
    test_name = name;
    idx = 0;
  endtask

  initial begin
    rst_n    = 1'b1;
    reqValid = 1'b1;
    target   = 2'd3;
    ovr      = 1'b0;
    ovr_dir  = 1'b0;
    ovr_stop = 1'b0;

    // 1: reset at a random time with active inputs
    start("reset");
    #($urandom_range(3, 27));
    rst_n = 1'b0;
    #1;
    e_idle(1, 2'd0);
    cmp_one();
    @(posedge clk);
    #1;
    e_idle(3, 2'd0);
    chk(3);
    reqValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e_idle(2, 2'd0);
    chk(2);

    // 2: request at current floor, held valid so the door cycle repeats
    start("same_floor");
    target = 2'd0;
    reqValid = 1'b1;
    e_idle(1, 2'd0); e_door(2'd0); e_idle(1, 2'd0); e_door(2'd0);
    chk(8);
    reqValid = 1'b0;
    e_idle(2, 2'd0);
    chk(2);

    // 3: floor 0 -> 2
    start("up_0_to_2");
    target = 2'd2;
    reqValid = 1'b1;
    e_idle(1, 2'd0); e_up(4, 2'd0); e_arr(2'd1); e_up(4, 2'd1); e_arr(2'd2); e_door(2'd2);
    chk(14);
    reqValid = 1'b0;
    e_idle(1, 2'd2);
    chk(1);

    // 4: reach floor 3, then 3 -> 1
    start("up_2_to_3");
    target = 2'd3;
    reqValid = 1'b1;
    e_idle(1, 2'd2); e_up(4, 2'd2); e_arr(2'd3); e_door(2'd3);
    chk(9);
    reqValid = 1'b0;
    e_idle(1, 2'd3);
    chk(1);
    start("down_3_to_1");
    target = 2'd1;
    reqValid = 1'b1;
    e_idle(1, 2'd3); e_dn(4, 2'd3); e_arr(2'd2); e_dn(4, 2'd2); e_arr(2'd1); e_door(2'd1);
    chk(14);
    reqValid = 1'b0;
    e_idle(1, 2'd1);
    chk(1);

    // 5: back to 0, then drop reqValid mid-travel toward 3
    start("down_1_to_0");
    target = 2'd0;
    reqValid = 1'b1;
    e_idle(1, 2'd1); e_dn(4, 2'd1); e_arr(2'd0); e_door(2'd0);
    chk(9);
    reqValid = 1'b0;
    e_idle(1, 2'd0);
    chk(1);
    start("drop_valid");
    target = 2'd3;
    reqValid = 1'b1;
    e_idle(1, 2'd0); e_up(4, 2'd0); e_arr(2'd1); e_idle(3, 2'd1);
    chk(2);
    reqValid = 1'b0;
    chk(7);

    // 6: out-of-range direction at floor 3 and floor 0, then reset mid-travel
    start("up_1_to_3");
    target = 2'd3;
    reqValid = 1'b1;
    e_idle(1, 2'd1); e_up(4, 2'd1); e_arr(2'd2); e_up(4, 2'd2); e_arr(2'd3); e_door(2'd3);
    chk(14);
    reqValid = 1'b0;
    e_idle(1, 2'd3);
    chk(1);
    start("force_up_at_3");
    ovr = 1'b1; ovr_dir = 1'b1; ovr_stop = 1'b0;
    reqValid = 1'b1;
    e_idle(4, 2'd3);
    chk(4);
    start("down_3_to_0");
    ovr = 1'b0;
    target = 2'd0;
    e_idle(1, 2'd3); e_dn(4, 2'd3); e_arr(2'd2); e_dn(4, 2'd2); e_arr(2'd1);
    e_dn(4, 2'd1); e_arr(2'd0); e_door(2'd0);
    chk(19);
    reqValid = 1'b0;
    e_idle(1, 2'd0);
    chk(1);
    start("force_down_at_0");
    ovr = 1'b1; ovr_dir = 1'b0; ovr_stop = 1'b0;
    reqValid = 1'b1;
    e_idle(4, 2'd0);
    chk(4);
    start("reset_mid_move");
    ovr = 1'b0;
    target = 2'd3;
    e_idle(1, 2'd0); e_up(4, 2'd0); e_arr(2'd1); e_up(2, 2'd1);
    chk(8);
    e_up(1, 2'd1);
    cmp_one();
    #2;
    rst_n = 1'b0;
    #1;
    e_idle(1, 2'd0);
    cmp_one();
    reqValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e_idle(2, 2'd0);
    chk(2);

    start("scoreboard_drained");
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=0 leftover entries", test_name, exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
